// File: rtl/ps2_rx_checked_pkg.sv
// rtl/ps2_rx_checked_pkg.sv - state encoding, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DPS  = 2'b01,
    LOAD = 2'b10
  } ps2_state_t;

  // Frame layout: start, d0..d7, parity, stop (LSB first on the wire)
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Data bits plus parity bit must contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_checked_if.sv
// rtl/ps2_rx_checked_if.sv - pin and result bundle between PS/2 receiver and its user
interface ps2_rx_checked_if;

  logic       PS2Data;
  logic       PS2Clk;
  logic       RxEnable;
  logic [7:0] Data;
  logic       Done;
  logic       ParityErr;
  logic       FrameErr;
  logic       TimeoutErr;
  logic       Busy;

  // Pin/enable driver side (device lines and packet assembler)
  modport master (
    output PS2Data, PS2Clk, RxEnable,
    input  Data, Done, ParityErr, FrameErr, TimeoutErr, Busy
  );

  // Receiver side
  modport slave (
    input  PS2Data, PS2Clk, RxEnable,
    output Data, Done, ParityErr, FrameErr, TimeoutErr, Busy
  );

endinterface

// File: rtl/ps2_rx_checked_clk_filter.sv
// rtl/ps2_rx_checked_clk_filter.sv - PS/2 pin synchronisers and PS2Clk glitch filter with falling-edge tick
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic fall_tick,
  output logic data_sync
);

  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  clk_filt_q;
  logic                  clk_filt_next;

  // Two-flop synchronisers; idle PS/2 lines are high, so they come out of reset at 1
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_raw};
      data_sync_q <= {data_sync_q[0], ps2_data_raw};
    end
  end

  // Sample history of the synchronised clock and the filtered clock itself
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      filt_q     <= '0;
      clk_filt_q <= 1'b0;
    end else begin
      filt_q     <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
      clk_filt_q <= clk_filt_next;
    end
  end

  // Filtered clock only moves once the whole history agrees; mixed history holds it
  always_comb begin
    clk_filt_next = clk_filt_q;
    if (&filt_q) begin
      clk_filt_next = 1'b1;
    end else if (~|filt_q) begin
      clk_filt_next = 1'b0;
    end
  end

  assign fall_tick = clk_filt_q && !clk_filt_next;
  assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_checked.sv
// rtl/ps2_rx_checked.sv - checked PS/2 frame receiver; optional watchdog under PS2_RX_TIMEOUT_EN
module ps2_rx_checked
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic             Clk,
  input logic             Reset,
  ps2_rx_checked_if.slave bus
);

  // Bits still to come after the start bit, minus one
  localparam logic [3:0] LAST_BIT_CNT = 4'd9;

  logic                      fall_tick;
  logic                      data_bit;
  ps2_state_t                state;
  ps2_state_t                state_next;
  logic [PS2_FRAME_BITS-1:0] shift_q;
  logic [3:0]                bit_cnt;
  logic [PS2_DATA_BITS-1:0]  data_q;
  logic                      start_frame;
  logic                      shift_en;
  logic                      load_en;
  logic                      timeout_hit;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .Clk         (Clk),
    .Reset       (Reset),
    .ps2_clk_raw (bus.PS2Clk),
    .ps2_data_raw(bus.PS2Data),
    .fall_tick   (fall_tick),
    .data_sync   (data_bit)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Watchdog: counts cycles since the last filtered falling edge while a frame is open
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wd_q <= '0;
    end else if (state != DPS || fall_tick || timeout_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign timeout_hit = (state == DPS) && (wd_q == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: frames open on a 0 start bit, advance on each tick, close after the stop bit
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    case (state)
      IDLE: begin
        // A 1 sampled here is line noise and is simply dropped
        if (fall_tick && bus.RxEnable && !data_bit) begin
          state_next  = DPS;
          start_frame = 1'b1;
          shift_en    = 1'b1;
        end
      end
      DPS: begin
        // A tick always beats the watchdog in the same cycle
        if (fall_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd0) begin
            state_next = LOAD;
            load_en    = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame shift register, bit counter and received-byte register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
    end else begin
      if (shift_en) begin
        shift_q <= {data_bit, shift_q[PS2_FRAME_BITS-1:1]};
      end
      if (start_frame) begin
        bit_cnt <= LAST_BIT_CNT;
      end else if (shift_en && bit_cnt != 4'd0) begin
        bit_cnt <= bit_cnt - 4'd1;
      end
      // Captured as the stop bit shifts in, so Data is already valid during Done
      if (load_en) begin
        data_q <= shift_q[PS2_DATA_BITS+1:2];
      end
    end
  end

  // Outputs: status flags are only meaningful in the single LOAD cycle
  always_comb begin
    bus.Done       = (state == LOAD);
    bus.ParityErr  = (state == LOAD) && !odd_parity_ok(shift_q[PS2_DATA_BITS+1:1]);
    bus.FrameErr   = (state == LOAD) && (shift_q[0] || !shift_q[PS2_FRAME_BITS-1]);
    bus.TimeoutErr = timeout_hit && !fall_tick;
    bus.Busy       = (state != IDLE);
  end

  assign bus.Data = data_q;

endmodule

// File: doc/ps2_rx_checked.md
Name: ps2_rx_checked

Overview:
Parametrised PS/2 device-to-host frame receiver. It is the successor to the basic PS/2 receiver in the mouse path.
- Adds input synchronisers and a configurable-length PS2Clk glitch filter.
- Checks the start bit, odd parity and stop bit.
- Holds received data in a register and raises a Busy flag.
- Optionally aborts stalled frames with a watchdog.
- Sits between the PS/2 pins and the mouse packet assembler; one instance per PS/2 port.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised PS2Clk samples needed to change the filtered clock (range 2..32)
TIMEOUT_CYCLES, 10000, Clk cycles allowed between filtered falling edges inside a frame before abort (about 200 us at 50 MHz; minimum 16)

Ports:
Clk  in  1  system clock; single clock domain
Reset  in  1  asynchronous, active-high reset
PS2Data  in  1  raw PS/2 data pin, asynchronous
PS2Clk  in  1  raw PS/2 clock pin, asynchronous
RxEnable  in  1  permits the start of a new frame; sampled only in IDLE
Data  out  8  last received byte, registered
Done  out  1  one-cycle pulse at the end of every complete frame
ParityErr  out  1  qualified by Done; 1 when the parity check failed
FrameErr  out  1  qualified by Done; 1 when start bit is not 0 or stop bit is not 1
TimeoutErr  out  1  one-cycle pulse when a frame is aborted by the watchdog
Busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset values:
  - Data=0; Done, ParityErr, FrameErr, TimeoutErr, Busy = 0.
  - Synchronisers=1; filter shift register=all 0; filtered clock=0.
  - State=IDLE; bit counter=0; shift register=0; watchdog=0.
- Input conditioning:
  - PS2Clk and PS2Data each pass through a 2-flop synchroniser.
  - The synchronised PS2Clk shifts into a FILTER_LEN-bit register.
  - Filtered clock goes to 1 when the register is all ones, to 0 when it is all zeros, and holds otherwise.
  - fall_tick = filtered clock is currently 1 and its next value is 0. It is combinational and lasts one cycle.
- Data is sampled from the synchronised PS2Data in the cycle fall_tick is high.
- Frame format: 11 bits, LSB first: start, d0..d7, parity, stop. An 11-bit shift register shifts right with the new bit entering at [10].
- FSM states: IDLE, DPS, LOAD.
  - IDLE: on fall_tick & RxEnable:
    - If the sampled bit is 0: shift it in, set bit counter=9, go to DPS, clear watchdog.
    - If the sampled bit is 1: remain in IDLE with no error; this is treated as line noise.
  - DPS: on fall_tick, shift, clear watchdog. If counter==0 go to LOAD, else decrement.
    - RxEnable is ignored in DPS; deasserting it does not abort a frame in progress.
  - LOAD (exactly one cycle):
    - Data <= shift[8:1].
    - Done=1.
    - ParityErr = ~(XOR of shift[9:1]), i.e. odd parity over data plus parity bit is required.
    - FrameErr = shift[0] | ~shift[10].
    - Next state is IDLE.
- Data is updated on every Done, including errored frames. It holds between Done pulses.
- ParityErr and FrameErr are asserted only in the Done cycle; both may be 1 together.
- Latency: Done rises one Clk after the fall_tick of the stop bit.
- A fall_tick arriving in LOAD is ignored. A frame can start again from the cycle after LOAD.
- Reset asserted mid-frame returns every register to its reset value immediately. The frame is discarded with no Done.

Optional Feature:
Macro PS2_RX_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width ceil(log2(TIMEOUT_CYCLES)) increments every cycle in DPS and clears on each fall_tick.
  - When it reaches TIMEOUT_CYCLES-1 with no fall_tick: go to IDLE, pulse TimeoutErr for one cycle, no Done, Data unchanged.
  - If the timeout and a fall_tick occur in the same cycle, the fall_tick wins and no timeout is raised.
- Undefined: no watchdog logic is built; TimeoutErr is tied to 0; DPS waits indefinitely.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding (IDLE=2'b00, DPS=2'b01, LOAD=2'b10).
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
  - Function odd_parity_ok(9-bit) returning 1 when the XOR is 1.
- Sub-module ps2_clk_filter, parameter FILTER_LEN:
  - Contains the two synchronisers and the filter.
  - Outputs fall_tick and the synchronised data bit.
  - Shared with the planned PS/2 transmitter.

Test Plan:
- Clean frame (FILTER_LEN=8, PS/2 bit period 2000 Clk): byte 0x5A, parity 1, stop 1 -> one Done, Data=0x5A, ParityErr=0, FrameErr=0; Busy high from the start-bit tick until the LOAD cycle.
- Parity fault: byte 0x5A with parity 0 -> Done with ParityErr=1, FrameErr=0, Data=0x5A.
- Stop fault: byte 0xFF, parity 1, stop 0 -> Done with FrameErr=1, ParityErr=0, Data=0xFF.
- Glitch rejection: 5-cycle low pulses on PS2Clk while idle with PS2Data=0 -> no state change; then a valid byte 0x01 is received correctly.
- RxEnable=0 during a full frame -> no Done and Busy stays 0. Also drop RxEnable after the start bit of a 0xC3 frame -> Done with Data=0xC3.
- PS2_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=100: send 4 bits then stop the clock -> TimeoutErr pulse at 100 cycles after the last tick, state IDLE, Data unchanged; the following 0x3C frame is received cleanly. Also assert Reset mid-frame -> all outputs 0 and no Done.
